// File: rtl/bcd_to_bin_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared sizing, state encoding and nibble constants for the
//            reverse double-dabble BCD-to-binary converter.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // Six decimal digits in, twenty binary bits out (999999 < 2^20).
  localparam int BCD_DIGITS = 6;
  localparam int BIN_W      = 20;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int SHIFT_W    = BCD_W + BIN_W;
  localparam int CNT_W      = $clog2(BIN_W);

  // A nibble at or above 8 after a right shift came from a decimal carry.
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_VAL    = 4'd3;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when a nibble holds a legal decimal digit.
  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= DIGIT_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_bin_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin_if
// Brief    : Start/busy/valid handshake plus digit and result bus of the
//            BCD-to-binary converter.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_to_bin_if;
  import bcd_pkg::*;

  logic             start;
  logic [3:0]       unit;
  logic [3:0]       ten;
  logic [3:0]       hun;
  logic [3:0]       tho;
  logic [3:0]       t_tho;
  logic [3:0]       h_hun;
  logic [BIN_W-1:0] data;
  logic             data_valid;
  logic             busy;
  logic             digit_err;

  // Requester side: supplies digits and start, consumes the result.
  modport master (
    output start, unit, ten, hun, tho, t_tho, h_hun,
    input  data, data_valid, busy, digit_err
  );

  // Converter side.
  modport slave (
    input  start, unit, ten, hun, tho, t_tho, h_hun,
    output data, data_valid, busy, digit_err
  );

endinterface
`default_nettype wire

// File: rtl/bcd_to_bin_nibble_sub3.sv
`default_nettype none
// ============================================================================
// Module   : bcd_nibble_sub3
// Brief    : Combinational per-nibble correction: subtract 3 when >= 8.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_nibble_sub3
  import bcd_pkg::*;
(
  input  wire logic [3:0] nib_in,
  output logic      [3:0] nib_out
);

  // Undo the half-weight carry that a right shift moved into this digit.
  always_comb begin
    nib_out = nib_in;
    if (nib_in >= ADJ_THRESH) begin
      nib_out = nib_in - ADJ_VAL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin
// Brief    : Sequential 6-digit BCD to 20-bit binary converter using reverse
//            double-dabble, one iteration per clock, start/busy/valid.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin
  import bcd_pkg::*;
(
  input  wire logic     sys_clk,
  input  wire logic     sys_rst,
  bcd_to_bin_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(BIN_W - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SHIFT_W-1:0] r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_data;
  logic               r_data_valid;
  logic               r_busy;
  logic               r_digit_err;

  logic               w_digits_ok;
  logic               w_accept;
  logic               w_reject;
  logic [SHIFT_W-1:0] w_load;
  logic [SHIFT_W-1:0] w_shifted;
  logic [SHIFT_W-1:0] w_iter;

  assign w_digits_ok = digit_ok(bus.unit)  && digit_ok(bus.ten)   &&
                       digit_ok(bus.hun)   && digit_ok(bus.tho)   &&
                       digit_ok(bus.t_tho) && digit_ok(bus.h_hun);

  assign w_load    = {bus.h_hun, bus.t_tho, bus.tho, bus.hun, bus.ten,
                      bus.unit, {BIN_W{1'b0}}};
  assign w_shifted = {1'b0, r_shift[SHIFT_W-1:1]};

  // The binary field passes through; only the BCD nibbles get corrected.
  assign w_iter[BIN_W-1:0] = w_shifted[BIN_W-1:0];

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_nib
      bcd_nibble_sub3 u_sub3 (
        .nib_in  (w_shifted[BIN_W + 4*gi +: 4]),
        .nib_out (w_iter[BIN_W + 4*gi +: 4])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and start acceptance/rejection.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_digits_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = CONV;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      CONV: begin
        if (r_cnt == c_cnt_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath, iteration counter and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_digit_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_digit_err  <= w_reject;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= w_load;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CONV: begin
          r_shift <= w_iter;
          r_cnt   <= r_cnt + 1'b1;
        end
        DONE: begin
          r_data       <= r_shift[BIN_W-1:0];
          r_data_valid <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  // Every decimal weight must have drained into the binary field by DONE.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && r_state == DONE) begin
      assert (r_shift[SHIFT_W-1:BIN_W] == '0);
    end
  end

  assign bus.data       = r_data;
  assign bus.data_valid = r_data_valid;
  assign bus.busy       = r_busy;
  assign bus.digit_err  = r_digit_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin
// Brief    : Directed self-checking bench for bcd_to_bin.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;

  logic sys_clk;
  logic sys_rst;
  int   n_cmp;
  int   n_bad;

  bcd_to_bin_if bus ();

  bcd_to_bin dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  // 50 MHz clock.
  initial begin
    sys_clk = 1'b0;
    forever #10 sys_clk = ~sys_clk;
  end

  task automatic set_digits(input logic [23:0] d);
    {bus.h_hun, bus.t_tho, bus.tho, bus.hun, bus.ten, bus.unit} = d;
  endtask

  // Present digits and start for one edge (edge k); returns #1 after edge k.
  task automatic start_conv(input logic [23:0] d);
    @(negedge sys_clk);
    set_digits(d);
    bus.start = 1'b1;
    @(posedge sys_clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges after edge k until data_valid is seen, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.data_valid && n < 40) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    sys_rst   = 1'b1;
    bus.start = 1'b0;
    set_digits(24'h000000);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    n_cmp++;
    if ({bus.data, bus.data_valid, bus.busy, bus.digit_err} !== 23'h0) begin
      n_bad++;
      $display("FAIL reset_state: got data=%h dv=%b busy=%b err=%b, want all 0",
               bus.data, bus.data_valid, bus.busy, bus.digit_err);
    end
  endtask

  task automatic test_max();
    int n;
    start_conv(24'h999999);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL max_busy: got %b want 1", bus.busy);
    end
    wait_valid(n);
    n_cmp++;
    if (n !== 21) begin
      n_bad++; $display("FAIL max_latency: got %0d want 21", n);
    end
    n_cmp++;
    if (bus.data !== 20'hF423F) begin
      n_bad++; $display("FAIL max_data: got %h want f423f", bus.data);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL max_busy_low: got %b want 0", bus.busy);
    end
    @(posedge sys_clk);
    #1;
    n_cmp++;
    if (bus.data_valid !== 1'b0) begin
      n_bad++; $display("FAIL max_dv_pulse: got %b want 0", bus.data_valid);
    end
  endtask

  task automatic test_digit_err();
    int seen;
    start_conv(24'h00A000);
    n_cmp++;
    if (bus.digit_err !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL err_pulse: got err=%b busy=%b want err=1 busy=0",
               bus.digit_err, bus.busy);
    end
    @(posedge sys_clk);
    #1;
    n_cmp++;
    if (bus.digit_err !== 1'b0) begin
      n_bad++; $display("FAIL err_one_cycle: got %b want 0", bus.digit_err);
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.data_valid || bus.busy) seen++;
      @(posedge sys_clk);
      #1;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL err_quiet: got %0d busy/valid cycles want 0", seen);
    end
    n_cmp++;
    if (bus.data !== 20'hF423F) begin
      n_bad++; $display("FAIL err_data_hold: got %h want f423f", bus.data);
    end
    set_digits(24'h000000);
  endtask

  task automatic test_values();
    int n;
    start_conv(24'h123456);
    wait_valid(n);
    n_cmp++;
    if (n !== 21 || bus.data !== 20'h1E240) begin
      n_bad++; $display("FAIL val_123456: got n=%0d data=%h want n=21 data=1e240", n, bus.data);
    end
    start_conv(24'h000000);
    wait_valid(n);
    n_cmp++;
    if (n !== 21 || bus.data !== 20'h00000) begin
      n_bad++; $display("FAIL val_zero: got n=%0d data=%h want n=21 data=00000", n, bus.data);
    end
  endtask

  task automatic test_ignore_starts();
    int pulses;
    int at;
    start_conv(24'h000042);
    pulses = 0;
    at     = 0;
    for (int n = 0; n <= 30; n++) begin
      if (bus.data_valid) begin
        pulses++;
        at = n;
        n_cmp++;
        if (bus.data !== 20'h0002A) begin
          n_bad++; $display("FAIL ign_data: got %h want 0002a", bus.data);
        end
      end
      if (n == 4 || n == 9) begin
        set_digits(24'h999999);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge sys_clk);
      #1;
    end
    bus.start = 1'b0;
    set_digits(24'h000000);
    n_cmp++;
    if (pulses !== 1 || at !== 21) begin
      n_bad++; $display("FAIL ign_single: got pulses=%0d at=%0d want 1 at 21", pulses, at);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    int seen;
    start_conv(24'h500000);
    repeat (9) begin
      @(posedge sys_clk);
      #1;
    end
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    n_cmp++;
    if (bus.data !== 20'h0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_state: got data=%h busy=%b want 0/0", bus.data, bus.busy);
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.data_valid) seen++;
      @(posedge sys_clk);
      #1;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL abort_no_valid: got %0d pulses want 0", seen);
    end
    start_conv(24'h500000);
    wait_valid(n);
    n_cmp++;
    if (n !== 21 || bus.data !== 20'h7A120) begin
      n_bad++; $display("FAIL abort_restart: got n=%0d data=%h want n=21 data=7a120", n, bus.data);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start_conv(24'h000042);
    wait_valid(n);
    n_cmp++;
    if (n !== 21 || bus.data !== 20'h0002A) begin
      n_bad++; $display("FAIL b2b_first: got n=%0d data=%h want n=21 data=0002a", n, bus.data);
    end
    // Still inside the data_valid cycle: request the next conversion.
    set_digits(24'h000001);
    bus.start = 1'b1;
    @(posedge sys_clk);
    #1;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL b2b_accept: got busy=%b want 1", bus.busy);
    end
    wait_valid(n);
    n_cmp++;
    if (n !== 21 || bus.data !== 20'h00001) begin
      n_bad++; $display("FAIL b2b_second: got n=%0d data=%h want n=21 data=00001", n, bus.data);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_max();
    test_digit_err();
    test_values();
    test_ignore_starts();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
